// File: rtl/timer_irq_ctrl_pkg.sv
// Shared definitions for the timer interrupt controller: register map,
// TCON bit positions and the interrupt-service FSM encoding.
package timer_irq_ctrl_pkg;

  localparam logic [31:0] OFF_TH   = 32'h0000_0000;
  localparam logic [31:0] OFF_TL   = 32'h0000_0004;
  localparam logic [31:0] OFF_TCON = 32'h0000_0008;

  localparam int TCON_RUN    = 0;
  localparam int TCON_IRQ_EN = 1;
  localparam int TCON_STATUS = 2;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_SERVICE = 1'b1
  } state_t;

  // Word-granular match: the two byte-offset bits never take part in decode.
  function automatic logic addr_hit(input logic [31:0] addr, input logic [31:0] reg_addr);
    return (addr & ~32'h3) == (reg_addr & ~32'h3);
  endfunction

endpackage

// File: rtl/timer_irq_ctrl_counter.sv
// Reload timer datapath: TH reload value, TL up-counter, TCON control/status
// and overflow detection.
module timer_counter
  import timer_irq_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_th_we,
  input  logic        i_tl_we,
  input  logic        i_tcon_we,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_th,
  output logic [31:0] o_tl,
  output logic [2:0]  o_tcon
);

  logic [31:0] r_th;
  logic [31:0] r_tl;
  logic        r_run;
  logic        r_irq_en;
  logic        r_status;
  logic        w_at_max;
  logic        w_overflow;

  assign w_at_max   = (r_tl == 32'hFFFF_FFFF);
  // A CPU store to TL pre-empts the counter, so it also suppresses overflow.
  assign w_overflow = r_run & w_at_max & ~i_tl_we;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_th <= 32'h0;
    end else if (i_th_we) begin
      r_th <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tl <= 32'h0;
    end else if (i_tl_we) begin
      r_tl <= i_wdata;
    end else if (r_run) begin
      r_tl <= w_at_max ? r_th : r_tl + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_run    <= 1'b0;
      r_irq_en <= 1'b0;
      r_status <= 1'b0;
    end else begin
      if (i_tcon_we) begin
        r_run    <= i_wdata[TCON_RUN];
        r_irq_en <= i_wdata[TCON_IRQ_EN];
      end
      // Set has priority over a software clear so an interrupt is never lost.
      if (w_overflow && r_irq_en) begin
        r_status <= 1'b1;
      end else if (i_tcon_we && !i_wdata[TCON_STATUS]) begin
        r_status <= 1'b0;
      end
    end
  end

  assign o_th   = r_th;
  assign o_tl   = r_tl;
  assign o_tcon = {r_status, r_irq_en, r_run};

endmodule

// File: rtl/timer_irq_ctrl.sv
// Memory-mapped timer with a single-level interrupt handshake: bus decode,
// read mux and the IDLE/SERVICE FSM around the timer_counter datapath.
module timer_irq_ctrl
  import timer_irq_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        wr,
  input  logic        rd,
  output logic [31:0] rdata,
  input  logic        irq_ack,
  input  logic        irq_ret,
  output logic        irq,
  output logic        in_service
);

  localparam logic [31:0] TH_ADDR   = BASE_ADDR + OFF_TH;
  localparam logic [31:0] TL_ADDR   = BASE_ADDR + OFF_TL;
  localparam logic [31:0] TCON_ADDR = BASE_ADDR + OFF_TCON;

  logic        w_sel_th;
  logic        w_sel_tl;
  logic        w_sel_tcon;
  logic [31:0] w_th;
  logic [31:0] w_tl;
  logic [2:0]  w_tcon;
  state_t      r_state;
  state_t      w_state_nxt;

  assign w_sel_th   = addr_hit(addr, TH_ADDR);
  assign w_sel_tl   = addr_hit(addr, TL_ADDR);
  assign w_sel_tcon = addr_hit(addr, TCON_ADDR);

  timer_counter u_timer_counter (
    .clk       (clk),
    .reset     (reset),
    .i_th_we   (wr & w_sel_th),
    .i_tl_we   (wr & w_sel_tl),
    .i_tcon_we (wr & w_sel_tcon),
    .i_wdata   (wdata),
    .o_th      (w_th),
    .o_tl      (w_tl),
    .o_tcon    (w_tcon)
  );

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    rdata = 32'h0;
    if (rd) begin
      if (w_sel_th) begin
        rdata = w_th;
      end else if (w_sel_tl) begin
        rdata = w_tl;
      end else if (w_sel_tcon) begin
        rdata = {29'h0, w_tcon};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (irq && irq_ack) w_state_nxt = ST_SERVICE;
      ST_SERVICE: if (irq_ret)        w_state_nxt = ST_IDLE;
      default:                        w_state_nxt = ST_IDLE;
    endcase
  end

  // Derived purely from registers, so there is no input-to-irq comb path.
  assign irq        = (r_state == ST_IDLE) & w_tcon[TCON_IRQ_EN] & w_tcon[TCON_STATUS];
  assign in_service = (r_state == ST_SERVICE);

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Scoreboard bench for timer_irq_ctrl: directed steps push expected
// {rdata, irq, in_service}; a monitor pops on every read strobe and compares.
module tb_timer_irq_ctrl;

  localparam logic [31:0] B = 32'h4000_0000;

  typedef struct {
    logic [31:0] rdata;
    logic        irq;
    logic        svc;
    string       name;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wr;
  logic        rd;
  logic [31:0] rdata;
  logic        irq_ack;
  logic        irq_ret;
  logic        irq;
  logic        in_service;

  exp_t q[$];
  int   vectors;
  int   miscompares;

  timer_irq_ctrl #(.BASE_ADDR(B)) dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .wdata      (wdata),
    .wr         (wr),
    .rd         (rd),
    .rdata      (rdata),
    .irq_ack    (irq_ack),
    .irq_ret    (irq_ret),
    .irq        (irq),
    .in_service (in_service)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: a read strobe is the point where the DUT presents a response.
  always @(negedge clk) begin
    if (rd) begin
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_read: rdata=%h irq=%b in_service=%b with no expectation queued",
                 rdata, irq, in_service);
      end else begin
        exp_t e;
        e = q.pop_front();
        vectors++;
        if (rdata !== e.rdata || irq !== e.irq || in_service !== e.svc) begin
          miscompares++;
          $display("FAIL %s: got rdata=%h irq=%b in_service=%b, expected rdata=%h irq=%b in_service=%b",
                   e.name, rdata, irq, in_service, e.rdata, e.irq, e.svc);
        end
      end
    end
  end

  task automatic step(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                      input logic ack, input logic ret, input logic [31:0] exp_rdata,
                      input logic exp_irq, input logic exp_svc, input string name);
    exp_t e;
    wr = w; rd = r; addr = a; wdata = d; irq_ack = ack; irq_ret = ret;
    if (r) begin
      e.rdata = exp_rdata; e.irq = exp_irq; e.svc = exp_svc; e.name = name;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0; irq_ack = 1'b0; irq_ret = 1'b0;
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    step(1'b1, 1'b0, a, d, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, "");
  endtask

  task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp_rdata, input logic exp_irq,
                        input logic exp_svc, input string name);
    step(1'b0, 1'b1, a, 32'h0, 1'b0, 1'b0, exp_rdata, exp_irq, exp_svc, name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations still queued", q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    vectors = 0; miscompares = 0;
    wr = 1'b0; rd = 1'b0; addr = 32'h0; wdata = 32'h0; irq_ack = 1'b0; irq_ret = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;
    @(posedge clk); #1;

    // Reset state, read while reset is held low
    rd_chk(B + 0, 32'h0, 1'b0, 1'b0, "rst_th");
    rd_chk(B + 8, 32'h0, 1'b0, 1'b0, "rst_tcon");
    reset = 1'b1;
    rd_chk(B + 4, 32'h0, 1'b0, 1'b0, "rst_tl");

    // Overflow reloads from TH, status/irq on the following cycle
    wr_reg(B + 0, 32'hFFFF_FFFC);
    wr_reg(B + 4, 32'hFFFF_FFFE);
    wr_reg(B + 8, 32'h3);
    rd_chk(B + 4, 32'hFFFF_FFFE, 1'b0, 1'b0, "cnt_fffe");
    rd_chk(B + 4, 32'hFFFF_FFFF, 1'b0, 1'b0, "cnt_ffff");
    rd_chk(B + 4, 32'hFFFF_FFFC, 1'b1, 1'b0, "ovf_reload");
    rd_chk(B + 8, 32'h7,         1'b1, 1'b0, "ovf_status");
    wr_reg(B + 8, 32'h6);                              // stop, keep status
    rd_chk(B + 8, 32'h6,         1'b1, 1'b0, "stop_keep_status");
    rd_chk(B + 4, 32'hFFFF_FFFF, 1'b1, 1'b0, "tl_holds");

    // Acknowledge, clear status, return with irq staying low
    step(1'b0, 1'b1, B + 8, 32'h0, 1'b1, 1'b0, 32'h6, 1'b1, 1'b0, "ack_cycle");
    rd_chk(B + 8, 32'h6, 1'b0, 1'b1, "in_service");
    wr_reg(B + 4, 32'h0);
    wr_reg(B + 8, 32'h3);
    step(1'b0, 1'b1, B + 8, 32'h0, 1'b0, 1'b1, 32'h3, 1'b0, 1'b1, "ret_cycle");
    rd_chk(B + 4, 32'h1, 1'b0, 1'b0, "idle_no_irq");

    // TL write while running, unmapped address, byte-offset ignored
    wr_reg(B + 4, 32'h10);
    rd_chk(B + 4,  32'h10, 1'b0, 1'b0, "tl_wr_10");
    rd_chk(B + 4,  32'h11, 1'b0, 1'b0, "tl_wr_11");
    rd_chk(B + 12, 32'h0,  1'b0, 1'b0, "unmapped");
    rd_chk(B + 6,  32'h13, 1'b0, 1'b0, "addr_lsb_ignored");

    // Second overflow during SERVICE is held off until return
    wr_reg(B + 4, 32'hFFFF_FFFD);
    rd_chk(B + 8, 32'h3,         1'b0, 1'b0, "pre_ovf2");
    rd_chk(B + 4, 32'hFFFF_FFFE, 1'b0, 1'b0, "cnt2_fffe");
    rd_chk(B + 8, 32'h3,         1'b0, 1'b0, "cnt2_ffff");
    rd_chk(B + 8, 32'h7,         1'b1, 1'b0, "ovf2_irq");
    step(1'b0, 1'b1, B + 8, 32'h0, 1'b1, 1'b0, 32'h7, 1'b1, 1'b0, "ack2_cycle");
    wr_reg(B + 8, 32'h3);
    rd_chk(B + 8, 32'h3,         1'b0, 1'b1, "svc_cleared");
    rd_chk(B + 8, 32'h7,         1'b0, 1'b1, "svc_no_nesting");
    step(1'b0, 1'b1, B + 4, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFD, 1'b0, 1'b1, "ret2_cycle");
    rd_chk(B + 8, 32'h7,         1'b1, 1'b0, "reassert_idle");

    // Overflow coincident with a status-clearing TCON write: set wins
    wr_reg(B + 8, 32'h3);
    rd_chk(B + 8, 32'h7,         1'b1, 1'b0, "set_beats_clear");

    // TL write in the overflow cycle: write wins, no status
    rd_chk(B + 4, 32'hFFFF_FFFD, 1'b1, 1'b0, "cnt3_fffd");
    wr_reg(B + 8, 32'h3);
    wr_reg(B + 4, 32'h55);
    rd_chk(B + 8, 32'h3,  1'b0, 1'b0, "tl_wr_no_ovf");
    rd_chk(B + 4, 32'h56, 1'b0, 1'b0, "tl_wr_55_cnt");

    // Clearing irq_en drops irq but keeps status
    wr_reg(B + 4, 32'hFFFF_FFFF);
    rd_chk(B + 8, 32'h3, 1'b0, 1'b0, "pre_ovf4");
    rd_chk(B + 8, 32'h7, 1'b1, 1'b0, "ovf4_irq");
    wr_reg(B + 8, 32'h5);
    rd_chk(B + 8, 32'h5, 1'b0, 1'b0, "irq_en_off");

    // TH write affects TL only at the next overflow
    wr_reg(B + 0, 32'h1234);
    rd_chk(B + 4, 32'hFFFF_FFFC, 1'b0, 1'b0, "old_th_reload");
    rd_chk(B + 4, 32'hFFFF_FFFD, 1'b0, 1'b0, "cnt5_fffd");
    rd_chk(B + 4, 32'hFFFF_FFFE, 1'b0, 1'b0, "cnt5_fffe");
    rd_chk(B + 4, 32'hFFFF_FFFF, 1'b0, 1'b0, "cnt5_ffff");
    rd_chk(B + 4, 32'h1234,      1'b0, 1'b0, "new_th_reload");
    rd_chk(B + 0, 32'h1234,      1'b0, 1'b0, "th_readback");

    // Reset during SERVICE with status pending
    wr_reg(B + 8, 32'h7);
    step(1'b0, 1'b1, B + 8, 32'h0, 1'b1, 1'b0, 32'h7, 1'b1, 1'b0, "ack3_cycle");
    rd_chk(B + 8, 32'h7, 1'b0, 1'b1, "svc_before_reset");
    reset = 1'b0;
    rd_chk(B + 8, 32'h0, 1'b0, 1'b0, "reset_mid_isr");
    rd_chk(B + 4, 32'h0, 1'b0, 1'b0, "reset_tl");
    reset = 1'b1;
    rd_chk(B + 8, 32'h0, 1'b0, 1'b0, "post_reset_tcon");
    rd_chk(B + 0, 32'h0, 1'b0, 1'b0, "post_reset_th");

    repeat (2) @(posedge clk);
    if (q.size() != 0) begin
      miscompares += q.size();
      $display("FAIL queue_drain: %0d expectations never observed, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
